// File: rtl/bp_pkg.sv
// Types and constants shared by the Decode-side branch predictor and the
// Execute-side branch resolver.
package bp_pkg;

   localparam int BP_XLEN    = 32;
   localparam int BP_HIST_W  = 8;
   localparam int INSN_BYTES = 4;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } bp_state_e;

   typedef struct packed {
      logic [BP_XLEN-1:0]   pc;
      logic                 taken;
      logic [BP_XLEN-1:0]   target;
      logic [BP_HIST_W-1:0] hist;
   } pred_entry_t;

   typedef struct packed {
      logic                 valid;
      logic [BP_XLEN-1:0]   pc;
      logic [BP_HIST_W-1:0] hist;
      logic                 taken;
      logic [BP_XLEN-1:0]   target;
   } upd_beat_t;

   localparam int ENTRY_W = $bits(pred_entry_t);

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight prediction queue: DEPTH-entry circular buffer with push, pop and
// a one-shot clear. Pointers carry one extra MSB to tell full from empty.
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic [ENTRY_W-1:0] push_data_i,
   input  logic               pop_i,
   input  logic               clear_i,
   output logic [ENTRY_W-1:0] head_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic               do_push;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o && !clear_i;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, (pop_i && !empty_o)};
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      // Clearing collapses the queue onto the read pointer, dropping everything queued.
      if (clear_i) begin
         wr_ptr_d = rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Execute-side branch resolver: checks queued predictions against actual
// outcomes, emits training beats and mispredict redirects. Define
// BRANCH_STATS_EN to add saturating resolve/mispredict counters.
module branch_resolver
   import bp_pkg::*;
#(
   parameter int XLEN   = BP_XLEN,
   parameter int DEPTH  = 8,
   parameter int HIST_W = BP_HIST_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pred_valid,
   output logic              pred_ready,
   input  logic [XLEN-1:0]   pred_pc,
   input  logic              pred_taken,
   input  logic [XLEN-1:0]   pred_target,
   input  logic [HIST_W-1:0] pred_hist,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic              res_taken,
   input  logic [XLEN-1:0]   res_target,
   output logic              upd_valid,
   output logic [XLEN-1:0]   upd_pc,
   output logic [HIST_W-1:0] upd_hist,
   output logic              upd_taken,
   output logic [XLEN-1:0]   upd_target,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              flush
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       stat_resolved,
   output logic [31:0]       stat_mispredict
`endif
);

   pred_entry_t        push_entry, head;
   logic [ENTRY_W-1:0] head_bits;
   logic               full, empty, push, pop, clear, mispredict;
   bp_state_e          state_q, state_d;
   logic               started_q;
   upd_beat_t          upd_q, upd_d;
   logic               redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

   assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target, hist: pred_hist};
   assign head       = pred_entry_t'(head_bits);

   // started_q keeps pred_ready low until the first clock after reset release.
   assign pred_ready = started_q && !full && (state_q == RUN);
   assign res_ready  = !empty && (state_q == RUN);
   assign push       = pred_valid && pred_ready;
   assign pop        = res_valid && res_ready;
   assign clear      = (state_q == FLUSH);
   assign mispredict = (head.taken != res_taken) || (res_taken && (head.target != res_target));

   bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clock),
      .rst_ni      (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .clear_i     (clear),
      .head_o      (head_bits),
      .full_o      (full),
      .empty_o     (empty)
   );

   always_comb begin
      state_d          = state_q;
      upd_d            = '0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      case (state_q)
         RUN:     if (pop && mispredict) state_d = FLUSH;
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
      if (pop) begin
         upd_d = '{valid: 1'b1, pc: head.pc, hist: head.hist, taken: res_taken, target: res_target};
         if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = res_taken ? res_target : head.pc + XLEN'(INSN_BYTES);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= RUN;
         started_q        <= 1'b0;
         upd_q            <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         started_q        <= 1'b1;
         upd_q            <= upd_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign upd_valid      = upd_q.valid;
   assign upd_pc         = upd_q.pc;
   assign upd_hist       = upd_q.hist;
   assign upd_taken      = upd_q.taken;
   assign upd_target     = upd_q.target;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush          = redirect_valid_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_resolved_q, stat_mispredict_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_resolved_q   <= '0;
         stat_mispredict_q <= '0;
      end else begin
         if (upd_q.valid && (stat_resolved_q != '1)) begin
            stat_resolved_q <= stat_resolved_q + 32'd1;
         end
         if (redirect_valid_q && (stat_mispredict_q != '1)) begin
            stat_mispredict_q <= stat_mispredict_q + 32'd1;
         end
      end
   end

   assign stat_resolved   = stat_resolved_q;
   assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, fill/wrap and reset
// sequences, and random traffic checked against a queue-based model.
module tb_branch_resolver;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 8;
   localparam int HIST_W = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              pred_valid, pred_taken, res_valid, res_taken;
   logic              pred_ready, res_ready;
   logic [XLEN-1:0]   pred_pc, pred_target, res_target;
   logic [HIST_W-1:0] pred_hist;
   logic              upd_valid, upd_taken, redirect_valid, flush;
   logic [XLEN-1:0]   upd_pc, upd_target, redirect_pc;
   logic [HIST_W-1:0] upd_hist;
`ifdef BRANCH_STATS_EN
   logic [31:0]       stat_resolved, stat_mispredict;
   int unsigned       s_res = 0, s_mis = 0;
`endif

   always #5 clock = ~clock;

   branch_resolver #(.XLEN(XLEN), .DEPTH(DEPTH), .HIST_W(HIST_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .pred_valid     (pred_valid),
      .pred_ready     (pred_ready),
      .pred_pc        (pred_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .pred_hist      (pred_hist),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_taken      (res_taken),
      .res_target     (res_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_hist       (upd_hist),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush)
`ifdef BRANCH_STATS_EN
      ,
      .stat_resolved  (stat_resolved),
      .stat_mispredict(stat_mispredict)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic [7:0]  hist;
   } ent_t;

   typedef struct {
      logic        pv;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptg;
      logic [7:0]  ph;
      logic        rv;
      logic        rt;
      logic [31:0] rtg;
      logic        x_upd;
      logic [31:0] x_upd_pc;
      logic        x_red;
      logic [31:0] x_red_pc;
   } vec_t;

   // Reference model: program-ordered queue of predictions plus a flush flag.
   ent_t        mq[$];
   bit          m_alive = 0, m_flush = 0;
   logic        e_upd_v = 0, e_upd_t = 0, e_red_v = 0;
   logic [31:0] e_upd_pc = 0, e_upd_tg = 0, e_red_pc = 0;
   logic [7:0]  e_upd_h = 0;
   int          n_cmp = 0, n_err = 0;
   vec_t        tbl[20];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0; pred_hist = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
   endtask

   // Called #1 after a rising edge; drives one cycle and checks both sides of it.
   task automatic do_cycle(input logic pv, input logic [31:0] pc, input logic pt,
                           input logic [31:0] ptg, input logic [7:0] ph,
                           input logic rv, input logic rt, input logic [31:0] rtg);
      bit   exp_pr, exp_rr, pf, rf, mis;
      ent_t h;
      pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptg; pred_hist = ph;
      res_valid = rv; res_taken = rt; res_target = rtg;
      #1;
      exp_pr = m_alive && (mq.size() < DEPTH) && !m_flush;
      exp_rr = (mq.size() > 0) && !m_flush;
      chk("pred_ready", pred_ready, exp_pr);
      chk("res_ready", res_ready, exp_rr);
      pf = pv && exp_pr;
      rf = rv && exp_rr;
      @(posedge clock);
      #1;
`ifdef BRANCH_STATS_EN
      if (e_upd_v && s_res != 32'hFFFF_FFFF) s_res++;
      if (e_red_v && s_mis != 32'hFFFF_FFFF) s_mis++;
`endif
      e_upd_v = 0;
      e_red_v = 0;
      if (m_flush) begin
         mq.delete();
         m_flush = 0;
      end else begin
         if (rf) begin
            h = mq.pop_front();
            e_upd_v = 1; e_upd_pc = h.pc; e_upd_h = h.hist; e_upd_t = rt; e_upd_tg = rtg;
            mis = (h.taken != rt) || (rt && (h.target != rtg));
            if (mis) begin
               e_red_v  = 1;
               e_red_pc = rt ? rtg : h.pc + 32'd4;
               m_flush  = 1;
            end
         end
         if (pf) mq.push_back('{pc, pt, ptg, ph});
      end
      m_alive = 1;
      chk("upd_valid", upd_valid, e_upd_v);
      chk("redirect_valid", redirect_valid, e_red_v);
      chk("flush", flush, e_red_v);
      if (e_upd_v) begin
         chk("upd_pc", upd_pc, e_upd_pc);
         chk("upd_hist", upd_hist, e_upd_h);
         chk("upd_taken", upd_taken, e_upd_t);
         chk("upd_target", upd_target, e_upd_tg);
      end
      if (e_red_v) chk("redirect_pc", redirect_pc, e_red_pc);
`ifdef BRANCH_STATS_EN
      chk("stat_resolved", stat_resolved, s_res);
      chk("stat_mispredict", stat_mispredict, s_mis);
`endif
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (mq.size() > 0 || m_flush); k++) begin
         if (mq.size() > 0 && !m_flush) do_cycle(0, 0, 0, 0, 0, 1, mq[0].taken, mq[0].target);
         else                           do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
      end
      chk("drained_res_ready", res_ready, 0);
   endtask

   initial begin
      //            pv pc            pt ptg        ph    rv rt rtg        xu xupc          xr xrpc
      tbl[0]  = '{1, 32'h100,      0, 32'h0,   8'h01, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[1]  = '{1, 32'h200,      0, 32'h0,   8'h02, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[2]  = '{1, 32'h300,      0, 32'h0,   8'h03, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[3]  = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 0, 32'h0,   1, 32'h100,     0, 32'h0};
      tbl[4]  = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 0, 32'h0,   1, 32'h200,     0, 32'h0};
      tbl[5]  = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 0, 32'h0,   1, 32'h300,     0, 32'h0};
      tbl[6]  = '{0, 32'h0,        0, 32'h0,   8'h00, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[7]  = '{1, 32'h40,       1, 32'h80,  8'h04, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[8]  = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 1, 32'h90,  1, 32'h40,      1, 32'h90};
      tbl[9]  = '{0, 32'h0,        0, 32'h0,   8'h00, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[10] = '{1, 32'h500,      1, 32'h600, 8'h05, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[11] = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 0, 32'h0,   1, 32'h500,     1, 32'h504};
      tbl[12] = '{0, 32'h0,        0, 32'h0,   8'h00, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[13] = '{1, 32'h700,      0, 32'h0,   8'h06, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[14] = '{1, 32'h900,      0, 32'h0,   8'h07, 1, 1, 32'h800, 1, 32'h700,     1, 32'h800};
      tbl[15] = '{0, 32'h0,        0, 32'h0,   8'h00, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[16] = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[17] = '{1, 32'hFFFFFFFC, 1, 32'h10,  8'h08, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};
      tbl[18] = '{0, 32'h0,        0, 32'h0,   8'h00, 1, 0, 32'h0,   1, 32'hFFFFFFFC, 1, 32'h0};
      tbl[19] = '{0, 32'h0,        0, 32'h0,   8'h00, 0, 0, 32'h0,   0, 32'h0,       0, 32'h0};

      drive_idle();
      reset = 0;
      #2;
      chk("rst_pred_ready", pred_ready, 0);
      chk("rst_res_ready", res_ready, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_flush", flush, 0);
      chk("rst_upd_pc", upd_pc, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1;
      #1 chk("release_pred_ready_low", pred_ready, 0);
      @(posedge clock);
      #1;
      m_alive = 1;
      chk("first_cycle_pred_ready", pred_ready, 1);
      chk("first_cycle_res_ready", res_ready, 0);

      foreach (tbl[i]) begin
         do_cycle(tbl[i].pv, tbl[i].pc, tbl[i].pt, tbl[i].ptg, tbl[i].ph,
                  tbl[i].rv, tbl[i].rt, tbl[i].rtg);
         chk("tbl_upd_valid", upd_valid, tbl[i].x_upd);
         if (tbl[i].x_upd) chk("tbl_upd_pc", upd_pc, tbl[i].x_upd_pc);
         chk("tbl_redirect_valid", redirect_valid, tbl[i].x_red);
         chk("tbl_flush", flush, tbl[i].x_red);
         if (tbl[i].x_red) chk("tbl_redirect_pc", redirect_pc, tbl[i].x_red_pc);
         $display("vec %0d: upd_valid=%0b upd_pc=%h redirect_valid=%0b redirect_pc=%h",
                  i, upd_valid, upd_pc, redirect_valid, redirect_pc);
      end

      // Fill to DEPTH, then push/pop pairs so both pointers wrap.
      for (int i = 0; i < DEPTH; i++)
         do_cycle(1, 32'h1000 + 32'(i * 16), 0, 0, 8'(i), 0, 0, 0);
      #1 chk("full_pred_ready", pred_ready, 0);
      for (int j = 0; j < DEPTH + 1; j++) begin
         do_cycle(1, 32'h2000 + 32'(j * 16), 0, 0, 8'(8'h40 + j), 1, 0, 0);
         $display("pair %0d: upd_pc=%h upd_hist=%h", j, upd_pc, upd_hist);
      end
      drain();

      for (int c = 0; c < 400; c++) begin
         logic [31:0] rpc, rtg;
         logic        rt;
         rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            rt  = mq[0].taken;
            rtg = mq[0].target;
         end else begin
            rt  = 1'($urandom_range(0, 1));
            rtg = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000;
         end
         do_cycle(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000, 8'($urandom),
                  1'($urandom_range(0, 1)), rt, rtg);
      end
      $display("random phase: %0d compared so far", n_cmp);
      drain();

      // Reset in the middle of a redirect/update cycle with entries still queued.
      for (int i = 0; i < 5; i++)
         do_cycle(1, 32'h3000 + 32'(i * 4), 0, 0, 8'(i), 0, 0, 0);
      do_cycle(0, 0, 0, 0, 0, 1, 1, 32'h3000);
      drive_idle();
      #2;
      reset = 0;
      #1;
      chk("async_upd_valid", upd_valid, 0);
      chk("async_upd_pc", upd_pc, 0);
      chk("async_redirect_valid", redirect_valid, 0);
      chk("async_redirect_pc", redirect_pc, 0);
      chk("async_flush", flush, 0);
      chk("async_pred_ready", pred_ready, 0);
      chk("async_res_ready", res_ready, 0);
      mq.delete();
      m_flush = 0; m_alive = 0; e_upd_v = 0; e_red_v = 0;
`ifdef BRANCH_STATS_EN
      s_res = 0; s_mis = 0;
      chk("async_stat_resolved", stat_resolved, 0);
      chk("async_stat_mispredict", stat_mispredict, 0);
`endif
      @(negedge clock);
      reset = 1;
      #1 chk("rerelease_pred_ready_low", pred_ready, 0);
      @(posedge clock);
      #1;
      m_alive = 1;
      chk("after_reset_pred_ready", pred_ready, 1);
      chk("after_reset_res_ready", res_ready, 0);
      chk("after_reset_upd_valid", upd_valid, 0);
      do_cycle(1, 32'h4000, 0, 0, 8'h11, 0, 0, 0);
      do_cycle(0, 0, 0, 0, 0, 1, 0, 0);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
